// File: rtl/key_search_dispatcher_if.sv
// Handshake bundle between the top-level search FSM/core array and the key-search dispatcher.
// The master side drives requests and reports; the slave (the dispatcher) returns grants and status.
interface key_search_dispatcher_if #(
  parameter int NUM_CORES     = 8,
  parameter int LOG_NUM_CORES = 3,
  parameter int KEY_WIDTH     = 24,
  parameter int COUNT_WIDTH   = 16
);
  logic                           start;
  logic                           mode;
  logic [NUM_CORES-1:0]           req;
  logic [NUM_CORES-1:0]           done_core;
  logic [NUM_CORES-1:0]           hit;
  logic [NUM_CORES*KEY_WIDTH-1:0] hit_key;
  logic [NUM_CORES-1:0]           grant;
  logic [KEY_WIDTH-1:0]           chunk_base;
  logic [KEY_WIDTH-1:0]           chunk_last;
  logic                           kill;
  logic                           running;
  logic                           found;
  logic                           failed;
  logic [KEY_WIDTH-1:0]           found_key;
  logic [LOG_NUM_CORES-1:0]       found_core;
  logic [COUNT_WIDTH-1:0]         hit_count;

  modport master (
    output start, mode, req, done_core, hit, hit_key,
    input  grant, chunk_base, chunk_last, kill, running, found, failed,
           found_key, found_core, hit_count
  );

  modport slave (
    input  start, mode, req, done_core, hit, hit_key,
    output grant, chunk_base, chunk_last, kill, running, found, failed,
           found_key, found_core, hit_count
  );
endinterface

// File: rtl/key_search_dispatcher.sv
// Dynamic chunk dispatcher for the RC4 key-search array: hands out key chunks to idle cores,
// tracks outstanding work, arbitrates hits and aborts or keeps counting depending on mode.
module key_search_dispatcher #(
  parameter int                   NUM_CORES     = 8,
  parameter int                   LOG_NUM_CORES = 3,
  parameter int                   KEY_WIDTH     = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX       = 24'h3FFFFF,
  parameter int                   CHUNK_LOG     = 14,
  parameter int                   COUNT_WIDTH   = 16
) (
  input logic                    clk,
  input logic                    reset,
  key_search_dispatcher_if.slave bus
);
  localparam int NB_W = KEY_WIDTH + 1;
  localparam logic [NB_W-1:0] CHUNK_SZ = NB_W'(1) << CHUNK_LOG;
  localparam logic [NB_W-1:0] CHUNK_M1 = CHUNK_SZ - NB_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_SUCCESS, S_FAIL} state_t;

  state_t                   state_q;
  logic [NUM_CORES-1:0]     busy_q;
  logic [NB_W-1:0]          next_base_q;
  logic                     mode_q;
  logic [NUM_CORES-1:0]     grant_q;
  logic [KEY_WIDTH-1:0]     chunk_base_q, chunk_last_q, found_key_q;
  logic                     kill_q, running_q, found_q, failed_q;
  logic [LOG_NUM_CORES-1:0] found_core_q;
  logic [COUNT_WIDTH-1:0]   hit_count_q;

  logic [NUM_CORES-1:0]     acc_hit, avail, grant_d;
  logic [LOG_NUM_CORES-1:0] hit_idx_d;
  logic [KEY_WIDTH-1:0]     hit_key_d, chunk_last_d;
  logic [NB_W-1:0]          chunk_end;
  logic [COUNT_WIDTH-1:0]   hit_count_d;

  // Saturating accumulate of the accepted-hit popcount.
  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic [NUM_CORES-1:0] v);
    logic [COUNT_WIDTH-1:0] s;
    s = a;
    for (int i = 0; i < NUM_CORES; i++)
      if (v[i] && (s != '1)) s = s + COUNT_WIDTH'(1);
    return s;
  endfunction

  always_comb begin
    acc_hit   = ((state_q == S_DISPATCH) || (state_q == S_DRAIN)) ? (bus.hit & busy_q) : '0;
    avail     = (state_q == S_DISPATCH) ? (bus.req & ~busy_q) : '0;
    grant_d   = '0;
    hit_idx_d = '0;
    hit_key_d = '0;
    // Descending scan so the lowest index wins both arbitrations.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (acc_hit[i]) begin
        hit_idx_d = LOG_NUM_CORES'(i);
        hit_key_d = bus.hit_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
      if (avail[i]) begin
        grant_d    = '0;
        grant_d[i] = 1'b1;
      end
    end
    chunk_end    = next_base_q + CHUNK_M1;
    chunk_last_d = (chunk_end > {1'b0, KEY_MAX}) ? KEY_MAX : chunk_end[KEY_WIDTH-1:0];
    hit_count_d  = sat_add(hit_count_q, acc_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= '0;
      next_base_q  <= '0;
      mode_q       <= 1'b0;
      grant_q      <= '0;
      chunk_base_q <= '0;
      chunk_last_q <= '0;
      kill_q       <= 1'b0;
      running_q    <= 1'b0;
      found_q      <= 1'b0;
      failed_q     <= 1'b0;
      found_key_q  <= '0;
      found_core_q <= '0;
      hit_count_q  <= '0;
    end else begin
      grant_q <= '0;
      kill_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_SUCCESS, S_FAIL: begin
          if (bus.start) begin
            state_q      <= S_DISPATCH;
            busy_q       <= '0;
            next_base_q  <= '0;
            mode_q       <= bus.mode;
            found_key_q  <= '0;
            found_core_q <= '0;
            hit_count_q  <= '0;
            running_q    <= 1'b1;
            found_q      <= 1'b0;
            failed_q     <= 1'b0;
          end
        end
        default: begin
          if (|acc_hit) begin
            hit_count_q <= hit_count_d;
            if (hit_count_q == '0) begin
              found_key_q  <= hit_key_d;
              found_core_q <= hit_idx_d;
            end
          end
          // In stop-on-first-hit mode an accepted hit pre-empts any grant this cycle.
          if ((|acc_hit) && !mode_q) begin
            kill_q    <= 1'b1;
            busy_q    <= '0;
            state_q   <= S_SUCCESS;
            running_q <= 1'b0;
            found_q   <= 1'b1;
          end else if ((state_q == S_DRAIN) && (busy_q == '0)) begin
            running_q <= 1'b0;
            if (hit_count_q != '0) begin
              state_q <= S_SUCCESS;
              found_q <= 1'b1;
            end else begin
              state_q  <= S_FAIL;
              failed_q <= 1'b1;
            end
          end else begin
            busy_q <= (busy_q & ~bus.done_core) | grant_d;
            if (|grant_d) begin
              grant_q      <= grant_d;
              chunk_base_q <= next_base_q[KEY_WIDTH-1:0];
              chunk_last_q <= chunk_last_d;
              next_base_q  <= next_base_q + CHUNK_SZ;
              if (chunk_last_d == KEY_MAX) state_q <= S_DRAIN;
            end
          end
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.chunk_base = chunk_base_q;
  assign bus.chunk_last = chunk_last_q;
  assign bus.kill       = kill_q;
  assign bus.running    = running_q;
  assign bus.found      = found_q;
  assign bus.failed     = failed_q;
  assign bus.found_key  = found_key_q;
  assign bus.found_core = found_core_q;
  assign bus.hit_count  = hit_count_q;
endmodule

// File: tb/tb_key_search_dispatcher.sv
// Bench for key_search_dispatcher: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model of the dispatcher kept in plain integer state.
module tb_key_search_dispatcher;
  localparam int NC = 4, LNC = 2, KW = 8, CL = 4, CW = 3;
  localparam logic [KW-1:0] KMAX = 8'hF5;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_search_dispatcher_if #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC), .KEY_WIDTH(KW),
                             .COUNT_WIDTH(CW)) bus ();
  key_search_dispatcher #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC), .KEY_WIDTH(KW), .KEY_MAX(KMAX),
                          .CHUNK_LOG(CL), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int n_assert = 0, n_fail = 0;
  // model state
  bit          m_run, m_drain, m_mode, m_found, m_failed, m_kill;
  bit [NC-1:0] m_busy, m_grant;
  int          m_nb, m_base, m_last, m_cnt, m_fkey, m_fcore;
  int          m_chunk[NC];
  // observation helpers
  int n_grants, obs_base, obs_last;
  bit kill_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_edge();
    int nacc, first, lo;
    m_grant = '0;
    m_kill  = 1'b0;
    if (reset) begin
      m_run = 0; m_drain = 0; m_mode = 0; m_found = 0; m_failed = 0; m_busy = '0;
      m_nb = 0; m_base = 0; m_last = 0; m_cnt = 0; m_fkey = 0; m_fcore = 0;
      return;
    end
    if (!m_run) begin
      if (bus.start) begin
        m_run = 1; m_drain = 0; m_mode = bus.mode; m_found = 0; m_failed = 0;
        m_busy = '0; m_nb = 0; m_cnt = 0; m_fkey = 0; m_fcore = 0;
      end
      return;
    end
    nacc = 0; first = -1;
    for (int i = 0; i < NC; i++)
      if (bus.hit[i] && m_busy[i]) begin
        nacc++;
        if (first < 0) first = i;
      end
    if (nacc > 0) begin
      if (m_cnt == 0) begin
        m_fcore = first;
        m_fkey  = int'(bus.hit_key[first*KW +: KW]);
      end
      m_cnt = (m_cnt + nacc > SAT) ? SAT : m_cnt + nacc;
    end
    if (nacc > 0 && !m_mode) begin
      m_kill = 1; m_busy = '0; m_run = 0; m_found = 1;
    end else if (m_drain && m_busy == 0) begin
      m_run = 0;
      if (m_cnt > 0) m_found = 1; else m_failed = 1;
    end else begin
      lo = -1;
      if (!m_drain)
        for (int i = NC - 1; i >= 0; i--) if (bus.req[i] && !m_busy[i]) lo = i;
      m_busy &= ~bus.done_core;
      if (lo >= 0) begin
        m_grant[lo] = 1'b1;
        m_busy[lo]  = 1'b1;
        m_base      = m_nb;
        m_last      = (m_nb + (1 << CL) - 1 > int'(KMAX)) ? int'(KMAX) : m_nb + (1 << CL) - 1;
        m_chunk[lo] = m_nb;
        m_nb       += 1 << CL;
        if (m_last == int'(KMAX)) m_drain = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("grant",      32'(bus.grant),      32'(m_grant));
    if (m_grant != 0) begin
      chk("chunk_base", 32'(bus.chunk_base), m_base);
      chk("chunk_last", 32'(bus.chunk_last), m_last);
    end
    chk("kill",       32'(bus.kill),       32'(m_kill));
    chk("running",    32'(bus.running),    32'(m_run));
    chk("found",      32'(bus.found),      32'(m_found));
    chk("failed",     32'(bus.failed),     32'(m_failed));
    chk("found_key",  32'(bus.found_key),  m_fkey);
    chk("found_core", 32'(bus.found_core), m_fcore);
    chk("hit_count",  32'(bus.hit_count),  m_cnt);
  endtask

  task automatic drive(input bit st, input bit md, input bit [NC-1:0] rq,
                       input bit [NC-1:0] dn, input bit [NC-1:0] ht);
    bus.start = st; bus.mode = md; bus.req = rq; bus.done_core = dn; bus.hit = ht;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (bus.grant != 0) begin
      n_grants++;
      obs_base = int'(bus.chunk_base);
      obs_last = int'(bus.chunk_last);
    end
    if (bus.kill) kill_seen = 1;
  endtask

  initial begin
    bit [NC-1:0]    ht;
    bit [NC*KW-1:0] hk;
    int             tgt[3];
    tgt = '{8'h05, 8'h22, 8'h39};

    // Reset state
    reset = 1'b1; bus.hit_key = '0; drive(0, 0, '0, '0, '0);
    step(); step();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_running", 32'(bus.running), 0);
    chk("rst_hit_count", 32'(bus.hit_count), 0);
    reset = 1'b0;

    // Four cores requesting: consecutive grants and chunks
    drive(1, 0, 4'hF, '0, '0); step();
    drive(0, 0, 4'hF, '0, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("s1_grant", 32'(bus.grant), 32'(1 << k));
      chk("s1_base", 32'(bus.chunk_base), 32'(k * 16));
      chk("s1_last", 32'(bus.chunk_last), 32'(k * 16 + 15));
    end
    // Core 1 frees up, then core 2 hits while core 1 would be granted
    drive(0, 0, 4'hF, 4'b0010, '0); step();
    bus.hit_key = {8'h00, 8'h27, 8'h00, 8'h00};
    drive(0, 0, 4'hF, '0, 4'b0100); step();
    chk("s2_grant", 32'(bus.grant), 0);
    chk("s2_kill", 32'(bus.kill), 1);
    chk("s2_found", 32'(bus.found), 1);
    chk("s2_found_key", 32'(bus.found_key), 32'h27);
    chk("s2_found_core", 32'(bus.found_core), 2);
    chk("s2_hit_count", 32'(bus.hit_count), 1);
    drive(0, 0, '0, '0, '0); step();
    chk("s2_kill_once", 32'(bus.kill), 0);

    // Simultaneous hits on cores 1 and 3
    drive(1, 0, 4'hF, '0, '0); step();
    drive(0, 0, 4'hF, '0, '0);
    for (int k = 0; k < 4; k++) step();
    bus.hit_key = {8'h33, 8'h00, 8'h15, 8'h00};
    drive(0, 0, '0, '0, 4'b1010); step();
    chk("s3_found_core", 32'(bus.found_core), 1);
    chk("s3_found_key", 32'(bus.found_key), 32'h15);
    chk("s3_hit_count", 32'(bus.hit_count), 2);

    // Exhaustive walk with no hits ends in FAIL after a clamped final chunk
    drive(1, 0, 4'hF, '0, '0); step();
    n_grants = 0;
    for (int c = 0; c < 300 && m_run; c++) begin
      drive(0, 0, 4'hF, m_busy, '0); step();
    end
    chk("s4_grants", 32'(n_grants), 16);
    chk("s4_last_base", 32'(obs_base), 32'hF0);
    chk("s4_last_last", 32'(obs_last), 32'hF5);
    chk("s4_failed", 32'(bus.failed), 1);
    chk("s4_running", 32'(bus.running), 0);

    // mode=1 with hits at 05, 22, 39
    drive(1, 1, '0, '0, '0); step();
    kill_seen = 0;
    for (int c = 0; c < 300 && m_run; c++) begin
      ht = '0; hk = '0;
      for (int i = 0; i < NC; i++)
        if (m_busy[i])
          for (int j = 0; j < 3; j++)
            if (m_chunk[i] <= tgt[j] && tgt[j] <= m_chunk[i] + 15) begin
              ht[i] = 1'b1;
              hk[i*KW +: KW] = KW'(tgt[j]);
            end
      bus.hit_key = hk;
      drive(0, 0, ~m_busy, m_busy, ht); step();
    end
    chk("s5_kill_seen", 32'(kill_seen), 0);
    chk("s5_found", 32'(bus.found), 1);
    chk("s5_hit_count", 32'(bus.hit_count), 3);
    chk("s5_found_key", 32'(bus.found_key), 32'h05);

    // mode=1, every chunk hits: counter saturates
    drive(1, 1, '0, '0, '0); step();
    for (int c = 0; c < 300 && m_run; c++) begin
      bus.hit_key = NC*KW'($urandom);
      drive(0, 0, ~m_busy, m_busy, m_busy); step();
    end
    chk("s6_hit_count_sat", 32'(bus.hit_count), 32'(SAT));
    chk("s6_found", 32'(bus.found), 1);

    // start ignored mid-search, hit from idle core ignored, then reset mid-DISPATCH
    drive(1, 0, 4'b0001, '0, '0); step();
    drive(0, 0, 4'b0001, '0, '0); step();
    bus.hit_key = {8'h44, 8'h00, 8'h00, 8'h00};
    drive(1, 0, 4'b0001, '0, 4'b1000); step();
    chk("s7_idle_hit_ignored", 32'(bus.hit_count), 0);
    chk("s7_still_running", 32'(bus.running), 1);
    drive(0, 0, 4'hF, '0, '0); step();
    reset = 1'b1; step();
    chk("s7_rst_running", 32'(bus.running), 0);
    chk("s7_rst_grant", 32'(bus.grant), 0);
    chk("s7_rst_kill", 32'(bus.kill), 0);
    reset = 1'b0;

    // Random traffic
    for (int r = 0; r < 6; r++) begin
      drive(1, bit'($urandom_range(0, 1)), NC'($urandom), '0, '0); step();
      for (int c = 0; c < 400 && m_run; c++) begin
        ht = m_busy & NC'($urandom) & NC'($urandom) & NC'($urandom) & NC'($urandom);
        if ($urandom_range(0, 9) == 0) ht |= ~m_busy & NC'($urandom);
        bus.hit_key = NC*KW'($urandom);
        drive(bit'($urandom_range(0, 30) == 0), bit'($urandom_range(0, 1)), NC'($urandom),
              m_busy & NC'($urandom), ht);
        step();
      end
      chk("rnd_ended", 32'(bus.running), 0);
      drive(0, 0, '0, '0, '0); step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
